// File: rtl/fir_capture_reader.sv
// fir_capture_reader: output-side reader for the FIR datapath.
// After a start request it discards FILL_SKIP pipeline-fill samples, captures DEPTH
// consecutive samples into local storage, then drains them oldest-first over a
// valid/ready stream. It also reports the saturated peak |sample| of the captured block.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   sample_in  filter output sample, one per cycle (two's complement)
//   start      capture request, honoured only when idle
//   busy       high while skipping, capturing or reading out
//   rd_valid   rd_data holds a captured sample
//   rd_ready   consumer accepts rd_data this cycle
//   rd_data    captured sample, oldest first (0 when not valid)
//   rd_last    rd_data is the final sample of the block
//   peak       max |sample| over the block, valid from readout until the next start
//   done       one-cycle pulse after the final handshake
module fir_capture_reader #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned FILL_SKIP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             start,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic [WIDTH-1:0] peak,
  output logic             done
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned SkipW = (FILL_SKIP > 1) ? $clog2(FILL_SKIP) : 1;
  localparam bit          HasSkip = (FILL_SKIP != 0);

  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(DEPTH - 1);
  // Unused when FILL_SKIP is 0: the skip state is never entered.
  localparam logic [SkipW-1:0] SkipLast = SkipW'(FILL_SKIP - 1);
  localparam logic [WIDTH-1:0] MaxPos   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSkip, StCapture, StReadout} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SkipW-1:0] skip_cnt_q, skip_cnt_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic             done_q, done_d;
  logic             mem_we;
  logic [WIDTH-1:0] sample_abs;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // |x| with the most negative code saturated to the largest positive code.
  always_comb begin
    sample_abs = sample_in;
    if (sample_in == MinNeg) begin
      sample_abs = MaxPos;
    end else if (sample_in[WIDTH-1]) begin
      sample_abs = ~sample_in + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    skip_cnt_d = skip_cnt_q;
    peak_d     = peak_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          skip_cnt_d = '0;
          peak_d     = '0;
          state_d    = HasSkip ? StSkip : StCapture;
        end
      end
      StSkip: begin
        skip_cnt_d = skip_cnt_q + 1'b1;
        if (skip_cnt_q == SkipLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (sample_abs > peak_q) begin
          peak_d = sample_abs;
        end
        if (wr_ptr_q == PtrLast) begin
          state_d = StReadout;
        end
      end
      StReadout: begin
        if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == PtrLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skip_cnt_q <= '0;
      peak_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skip_cnt_q <= skip_cnt_d;
      peak_q     <= peak_d;
      done_q     <= done_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    rd_valid = (state_q == StReadout);
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    rd_last  = rd_valid && (rd_ptr_q == PtrLast);
    peak     = peak_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_fir_capture_reader.sv
module tb_fir_capture_reader;

  localparam int DA  = 64;
  localparam int FSA = 8;
  localparam int DB  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        start_a, rd_ready_a, start_b, rd_ready_b;
  logic        busy_a, rd_valid_a, rd_last_a, done_a;
  logic        busy_b, rd_valid_b, rd_last_b, done_b;
  logic [15:0] rd_data_a, peak_a, rd_data_b, peak_b;

  always #5 clk = ~clk;

  fir_capture_reader #(.WIDTH(16), .DEPTH(DA), .FILL_SKIP(FSA)) u_dut_a (
    .clk(clk), .reset(reset), .sample_in(sample_in), .start(start_a), .busy(busy_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a), .rd_last(rd_last_a),
    .peak(peak_a), .done(done_a)
  );

  fir_capture_reader #(.WIDTH(16), .DEPTH(DB), .FILL_SKIP(0)) u_dut_b (
    .clk(clk), .reset(reset), .sample_in(sample_in), .start(start_b), .busy(busy_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
    .peak(peak_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int smode = 0;  // 0 random, 1 ramp, 2 small random in [-299, 299]
  int blk_base = -1;
  logic [15:0] hist [int];
  logic [15:0] inj [64];
  bit          inj_on [64];

  // Advance to the next negedge; inputs set afterwards are sampled at the following posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (smode)
      1:       sample_in = 16'(cyc);
      2:       sample_in = 16'($urandom_range(598)) - 16'd299;
      default: sample_in = 16'($urandom);
    endcase
    if (blk_base >= 0 && cyc >= blk_base && cyc < blk_base + 64) begin
      if (inj_on[cyc - blk_base]) sample_in = inj[cyc - blk_base];
    end
    hist[cyc] = sample_in;
  endtask

  function automatic int sat_abs(logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic clear_inj();
    for (int i = 0; i < 64; i++) inj_on[i] = 1'b0;
  endtask

  task automatic start_a_now(output int c);
    start_a  = 1'b1;
    c        = cyc;
    blk_base = c + 1 + FSA;
    tick();
    start_a  = 1'b0;
  endtask

  task automatic wait_valid_a(input int c, input bit pulse);
    int guard = 0;
    while (!rd_valid_a && guard < 200) begin
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL busy_pre_readout: cyc=%0d busy=%b required 1", cyc, busy_a);
      end
      start_a = pulse && (cyc == c + 3 || cyc == c + 30);
      tick();
      start_a = 1'b0;
      guard++;
    end
    checks++;
    if (rd_valid_a !== 1'b1 || cyc != c + 1 + FSA + DA) begin
      errors++;
      $display("FAIL valid_latency: rd_valid=%b at %0d cycles after start, required 1 at %0d",
               rd_valid_a, cyc - c, 1 + FSA + DA);
    end
  endtask

  task automatic drain_a(input int c, input int rmode, input bit pulse, input bit restart,
                         output int c2);
    logic [15:0] expv [64];
    int pk = 0;
    int idx = 0;
    int guard = 0;
    bit r;
    for (int i = 0; i < DA; i++) begin
      expv[i] = hist[c + 1 + FSA + i];
      if (sat_abs(expv[i]) > pk) pk = sat_abs(expv[i]);
    end
    c2 = -1;
    while (idx < DA && guard < 1000) begin
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== expv[idx] || rd_last_a !== (idx == DA - 1)) begin
        errors++;
        $display("FAIL drain_data[%0d]: valid=%b data=%h last=%b required 1 %h %b", idx,
                 rd_valid_a, rd_data_a, rd_last_a, expv[idx], (idx == DA - 1));
      end
      checks++;
      if (peak_a !== 16'(pk)) begin
        errors++;
        $display("FAIL drain_peak: got %h required %h", peak_a, 16'(pk));
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (guard % 2) == 0;
        default: r = 1'($urandom_range(1));
      endcase
      rd_ready_a = r;
      start_a    = pulse && (guard == 5);
      tick();
      start_a = 1'b0;
      guard++;
      if (r) idx++;
    end
    rd_ready_a = 1'b0;
    checks++;
    if (idx != DA) begin
      errors++;
      $display("FAIL handshake_count: got %0d required %0d", idx, DA);
    end
    checks++;
    if (done_a !== 1'b1 || rd_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1 0 0", done_a, rd_valid_a,
               busy_a);
    end
    if (restart) begin
      start_a  = 1'b1;
      c2       = cyc;
      blk_base = c2 + 1 + FSA;
    end
    tick();
    start_a = 1'b0;
    checks++;
    if (done_a !== 1'b0 || busy_a !== restart) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b required 0 %b", done_a, busy_a, restart);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({busy_a, rd_valid_a, rd_last_a, done_a} !== 4'b0 || rd_data_a !== 16'h0 ||
        peak_a !== 16'h0) begin
      errors++;
      $display("FAIL %s: busy=%b valid=%b last=%b done=%b data=%h peak=%h required all 0",
               name, busy_a, rd_valid_a, rd_last_a, done_a, rd_data_a, peak_a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset_a");
    checks++;
    if ({busy_b, rd_valid_b, rd_last_b, done_b} !== 4'b0 || rd_data_b !== 16'h0 ||
        peak_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_b: busy=%b valid=%b last=%b done=%b data=%h peak=%h required all 0",
               busy_b, rd_valid_b, rd_last_b, done_b, rd_data_b, peak_b);
    end
    reset = 1'b0;
    repeat (2) tick();
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_ramp();
    int c, c2;
    smode = 1;
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    checks++;
    if (rd_data_a !== 16'(c + 1 + FSA)) begin
      errors++;
      $display("FAIL ramp_first: got %h required %h", rd_data_a, 16'(c + 1 + FSA));
    end
    drain_a(c, 0, 1'b0, 1'b0, c2);
    smode = 0;
  endtask

  task automatic test_backpressure();
    int c, c2;
    smode = 0;
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    drain_a(c, 1, 1'b0, 1'b0, c2);
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    drain_a(c, 2, 1'b0, 1'b0, c2);
  endtask

  task automatic test_peak();
    int c, c2;
    smode = 0;
    clear_inj();
    inj[5] = 16'd100;  inj_on[5] = 1'b1;
    inj[20] = 16'hFED4; inj_on[20] = 1'b1;
    inj[40] = 16'h8000; inj_on[40] = 1'b1;
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    checks++;
    if (peak_a !== 16'h7FFF) begin
      errors++;
      $display("FAIL peak_saturate: got %h required 7fff", peak_a);
    end
    drain_a(c, 0, 1'b0, 1'b0, c2);
    clear_inj();
    smode = 2;
    inj[33] = 16'hFED4; inj_on[33] = 1'b1;
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    checks++;
    if (peak_a !== 16'd300) begin
      errors++;
      $display("FAIL peak_neg300: got %0d required 300", peak_a);
    end
    drain_a(c, 2, 1'b0, 1'b0, c2);
    clear_inj();
    smode = 0;
  endtask

  task automatic test_back_to_back();
    int c, c2, c3;
    smode = 0;
    start_a_now(c);
    wait_valid_a(c, 1'b1);
    drain_a(c, 1, 1'b1, 1'b1, c2);
    wait_valid_a(c2, 1'b0);
    drain_a(c2, 2, 1'b0, 1'b0, c3);
  endtask

  task automatic test_reset_mid();
    int c, c2;
    smode = 0;
    start_a_now(c);
    while (cyc < c + 30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("reset_mid_capture");
    repeat (3) begin
      tick();
      check_idle_zero("idle_after_capture_abort");
    end
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    drain_a(c, 0, 1'b0, 1'b0, c2);

    start_a_now(c);
    wait_valid_a(c, 1'b0);
    rd_ready_a = 1'b1;
    repeat (10) tick();
    rd_ready_a = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("reset_mid_readout");
    tick();
    check_idle_zero("idle_after_readout_abort");
    start_a_now(c);
    wait_valid_a(c, 1'b0);
    drain_a(c, 2, 1'b0, 1'b0, c2);
  endtask

  task automatic test_no_skip();
    int c;
    int guard = 0;
    int idx = 0;
    int pk = 0;
    logic [15:0] expv [8];
    smode = 0;
    start_b = 1'b1;
    c = cyc;
    tick();
    start_b = 1'b0;
    while (!rd_valid_b && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (rd_valid_b !== 1'b1 || cyc != c + 1 + DB) begin
      errors++;
      $display("FAIL noskip_latency: valid=%b after %0d cycles required 1 after %0d", rd_valid_b,
               cyc - c, 1 + DB);
    end
    for (int i = 0; i < DB; i++) begin
      expv[i] = hist[c + 1 + i];
      if (sat_abs(expv[i]) > pk) pk = sat_abs(expv[i]);
    end
    checks++;
    if (peak_b !== 16'(pk)) begin
      errors++;
      $display("FAIL noskip_peak: got %h required %h", peak_b, 16'(pk));
    end
    rd_ready_b = 1'b1;
    while (idx < DB && guard < 100) begin
      checks++;
      if (rd_valid_b !== 1'b1 || rd_data_b !== expv[idx] || rd_last_b !== (idx == DB - 1)) begin
        errors++;
        $display("FAIL noskip_data[%0d]: valid=%b data=%h last=%b required 1 %h %b", idx,
                 rd_valid_b, rd_data_b, rd_last_b, expv[idx], (idx == DB - 1));
      end
      tick();
      guard++;
      idx++;
    end
    rd_ready_b = 1'b0;
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL noskip_done: done=%b busy=%b required 1 0", done_b, busy_b);
    end
  endtask

  initial begin
    reset = 1'b1;
    sample_in = 16'h0;
    start_a = 1'b0;
    rd_ready_a = 1'b0;
    start_b = 1'b0;
    rd_ready_b = 1'b0;
    clear_inj();
    test_reset();
    test_ramp();
    test_backpressure();
    test_peak();
    test_back_to_back();
    test_reset_mid();
    test_no_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
